// File: rtl/mmio_uart_pkg.sv
// Shared address map, STATUS bit layout and transmitter state encoding
// for the memory-mapped UART transmitter.
package mmio_uart_pkg;

   localparam logic [31:0] TXDATA_ADDR = 32'h0000_00F0;
   localparam logic [31:0] STATUS_ADDR = 32'h0000_00F4;

   localparam int STAT_FULL   = 0;
   localparam int STAT_EMPTY  = 1;
   localparam int STAT_TXBUSY = 2;
   localparam int STAT_OVF    = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO. A push on a full FIFO is
// accepted only when a pop happens in the same cycle.
module byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic [7:0]  mem [DEPTH];
   logic        wr_en;
   logic        rd_en;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign dout  = mem[rptr[AW-1:0]];

   // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr[AW-1:0]] <= din;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_en) wptr <= wptr + 1'b1;
         if (rd_en) rptr <= rptr + 1'b1;
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores feed a byte FIFO that a
// registered-output FSM drains onto txd, LSB first.
module mmio_uart_tx
   import mmio_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic        sbM,
   input  logic [31:0] dataadr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        hit,
   output logic        txd,
   output logic        busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   tx_state_t     state;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shreg;
   logic          ovf;

   logic          hit_tx;
   logic          hit_st;
   logic          wr_tx;
   logic          wr_st;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic [7:0]    fifo_dout;
   logic          txbusy;
   logic          unused_bits;

   // Byte and word stores both carry the byte in the low lane.
   assign unused_bits = ^{sbM, writedata[31:8]};

   assign hit_tx = (dataadr == TXDATA_ADDR);
   assign hit_st = (dataadr == STATUS_ADDR);
   assign hit    = hit_tx || hit_st;
   assign wr_tx  = memwrite && hit_tx;
   assign wr_st  = memwrite && hit_st;

   // Pop is decided from registered state only, so a byte pushed into an
   // empty FIFO is seen by the FSM one cycle later.
   assign pop    = (state == IDLE) && !empty;
   assign push   = wr_tx;
   assign txbusy = (state != IDLE);
   assign busy   = txbusy || !empty;

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (writedata[7:0]),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf <= 1'b0;
      end else if (wr_tx && full && !pop) begin
         ovf <= 1'b1;
      end else if (wr_st && writedata[STAT_OVF]) begin
         ovf <= 1'b0;
      end
   end

   always_comb begin
      // NOTE: assign a default before any branch so no latch is inferred.
      readdata = '0;
      if (hit_st) begin
         readdata[STAT_FULL]   = full;
         readdata[STAT_EMPTY]  = empty;
         readdata[STAT_TXBUSY] = txbusy;
         readdata[STAT_OVF]    = ovf;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         txd   <= 1'b1;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
      end else begin
         case (state)
            IDLE: begin
               txd <= 1'b1;
               cnt <= '0;
               idx <= '0;
               if (!empty) begin
                  shreg <= fifo_dout;
                  txd   <= 1'b0;
                  state <= START;
               end
            end
            START: begin
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  idx   <= '0;
                  txd   <= shreg[0];
                  state <= DATA;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (idx == 3'd7) begin
                     txd   <= 1'b1;
                     state <= STOP;
                  end else begin
                     idx <= idx + 3'd1;
                     txd <= shreg[idx + 3'd1];
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            STOP: begin
               txd <= 1'b1;
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               txd   <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4; a line
// decoder collects every completed frame from txd for comparison.
module tb_mmio_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam logic [31:0] A_TX = 32'h0000_00F0;
   localparam logic [31:0] A_ST = 32'h0000_00F4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        memwrite = 1'b0;
   logic        sbM = 1'b0;
   logic [31:0] dataadr = '0;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        hit;
   logic        txd;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   mmio_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .memwrite  (memwrite),
      .sbM       (sbM),
      .dataadr   (dataadr),
      .writedata (writedata),
      .readdata  (readdata),
      .hit       (hit),
      .txd       (txd),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Line decoder: frame starts on the first low sample, data sampled mid-bit.
   logic       dec_on = 1'b0;
   int         dec_k = 0;
   logic [7:0] dec_b = '0;
   int         stop_errs = 0;
   logic [7:0] rxq[$];
   int         startq[$];

   always @(negedge clk) begin
      if (!reset) begin
         dec_on <= 1'b0;
      end else if (!dec_on) begin
         if (txd == 1'b0) begin
            dec_on <= 1'b1;
            dec_k  <= 1;
            startq.push_back(cyc);
         end
      end else begin
         dec_k <= dec_k + 1;
         if (dec_k >= 4 && dec_k < 36 && (dec_k % 4) == 2)
            dec_b[3'((dec_k - 4) / 4)] <= txd;
         if (dec_k == 38 && txd !== 1'b1)
            stop_errs <= stop_errs + 1;
         if (dec_k == 39) begin
            dec_on <= 1'b0;
            rxq.push_back(dec_b);
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic s);
      @(negedge clk);
      dataadr   = a;
      writedata = d;
      sbM       = s;
      memwrite  = 1'b1;
      @(negedge clk);
      memwrite  = 1'b0;
      dataadr   = '0;
      writedata = '0;
      sbM       = 1'b0;
   endtask

   task automatic burst(input logic [7:0] first, input int n);
      @(negedge clk);
      dataadr  = A_TX;
      sbM      = 1'b1;
      memwrite = 1'b1;
      for (int i = 0; i < n; i++) begin
         writedata = {24'h0, first + 8'(i)};
         @(negedge clk);
      end
      memwrite  = 1'b0;
      dataadr   = '0;
      writedata = '0;
      sbM       = 1'b0;
   endtask

   task automatic read_reg(input logic [31:0] a, output logic [31:0] rd, output logic h);
      dataadr  = a;
      memwrite = 1'b0;
      #1;
      rd = readdata;
      h  = hit;
      dataadr = '0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_timeout"}, 64'(n >= 3000), 64'(0));
      repeat (2) @(negedge clk);
   endtask

   task automatic clear_rx();
      rxq.delete();
      startq.delete();
   endtask

   task automatic check_rx(input string tag, input int n, input logic [47:0] exp);
      check({tag, "_count"}, 64'(rxq.size()), 64'(n));
      for (int i = 0; i < n; i++)
         check($sformatf("%s_byte%0d", tag, i),
               (i < rxq.size()) ? 64'(rxq[i]) : 64'hFFFF, 64'(exp[8*i +: 8]));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        h;
      logic [63:0] obs;
      logic [63:0] expv;
      logic [7:0]  b;
      logic        busy_last;
      int          waits;

      // Reset and idle
      repeat (3) @(negedge clk);
      check("rst_txd", 64'(txd), 64'(1));
      check("rst_busy", 64'(busy), 64'(0));
      read_reg(A_ST, rd, h);
      check("rst_status", 64'(rd), 64'h2);
      @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      check("idle_txd", 64'(txd), 64'(1));
      check("idle_busy", 64'(busy), 64'(0));
      read_reg(A_ST, rd, h);
      check("idle_status", 64'(rd), 64'h2);
      check("idle_status_hit", 64'(h), 64'(1));

      // Single byte store, exact waveform
      clear_rx();
      store(A_TX, 32'h0000_00A5, 1'b1);
      check("a5_pre_txd", 64'(txd), 64'(1));
      waits = 0;
      while (txd !== 1'b0 && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      check("a5_latency", 64'(waits), 64'(1));
      obs = '0;
      busy_last = 1'b0;
      for (int i = 0; i < 40; i++) begin
         obs[i] = txd;
         if (i == 39) busy_last = busy;
         if (i < 39) @(negedge clk);
      end
      b = 8'hA5;
      expv = '0;
      for (int i = 0; i < 40; i++)
         expv[i] = (i < 4) ? 1'b0 : (i < 36) ? b[3'((i - 4) / 4)] : 1'b1;
      check("a5_wave", obs, expv);
      check("a5_busy_stop", 64'(busy_last), 64'(1));
      @(negedge clk);
      check("a5_busy_after", 64'(busy), 64'(0));
      check("a5_txd_after", 64'(txd), 64'(1));
      check_rx("a5", 1, 48'hA5);

      // Word store (sbM=0) sends only the low byte
      clear_rx();
      store(A_TX, 32'hDEAD_BE3C, 1'b0);
      wait_idle("word");
      check_rx("word", 1, 48'h3C);

      // Five consecutive stores: one popped, four fill the FIFO
      clear_rx();
      burst(8'h11, 5);
      read_reg(A_ST, rd, h);
      check("burst5_status", 64'(rd), 64'h5);
      wait_idle("burst5");
      check_rx("burst5", 5, 48'h15_14_13_12_11);
      for (int i = 1; i < startq.size(); i++)
         check($sformatf("burst5_gap%0d", i), 64'(startq[i] - startq[i-1]), 64'(41));
      read_reg(A_ST, rd, h);
      check("burst5_end_status", 64'(rd), 64'h2);

      // Six consecutive stores: sixth dropped, OVF sticky, W1C clear
      clear_rx();
      burst(8'h21, 6);
      read_reg(A_ST, rd, h);
      check("ovf_status_set", 64'(rd), 64'hD);
      store(A_ST, 32'h0000_0007, 1'b0);
      read_reg(A_ST, rd, h);
      check("ovf_status_nonw1c", 64'(rd), 64'hD);
      store(A_ST, 32'h0000_0008, 1'b0);
      read_reg(A_ST, rd, h);
      check("ovf_status_clr", 64'(rd), 64'h5);
      wait_idle("ovf");
      check_rx("ovf", 5, 48'h25_24_23_22_21);

      // Push coinciding with pop on a full FIFO
      clear_rx();
      burst(8'h31, 5);
      repeat (37) @(negedge clk);
      dataadr   = A_TX;
      writedata = 32'h0000_0036;
      sbM       = 1'b1;
      memwrite  = 1'b1;
      @(negedge clk);
      memwrite  = 1'b0;
      dataadr   = '0;
      read_reg(A_ST, rd, h);
      check("fullpop_status", 64'(rd), 64'h5);
      wait_idle("fullpop");
      check_rx("fullpop", 6, 48'h36_35_34_33_32_31);

      // Non-hit store and TXDATA read
      clear_rx();
      @(negedge clk);
      dataadr   = 32'h0000_0100;
      writedata = 32'h0000_0077;
      memwrite  = 1'b1;
      #1;
      check("nohit_hit", 64'(hit), 64'(0));
      check("nohit_readdata", 64'(readdata), 64'h0);
      @(negedge clk);
      memwrite = 1'b0;
      dataadr  = '0;
      check("nohit_busy", 64'(busy), 64'(0));
      repeat (50) @(negedge clk);
      check_rx("nohit", 0, 48'h0);
      read_reg(A_TX, rd, h);
      check("txdata_readdata", 64'(rd), 64'h0);
      check("txdata_hit", 64'(h), 64'(1));

      // Reset in the middle of DATA bit 3, with another byte queued
      clear_rx();
      @(negedge clk);
      dataadr   = A_TX;
      sbM       = 1'b1;
      writedata = 32'h0000_00A5;
      memwrite  = 1'b1;
      @(negedge clk);
      writedata = 32'h0000_0077;
      @(negedge clk);
      memwrite  = 1'b0;
      dataadr   = '0;
      repeat (18) @(negedge clk);
      check("bit3_txd", 64'(txd), 64'(0));
      check("bit3_busy", 64'(busy), 64'(1));
      #2 reset = 1'b0;
      #1;
      check("abort_txd", 64'(txd), 64'(1));
      check("abort_busy", 64'(busy), 64'(0));
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      check("rel_busy", 64'(busy), 64'(0));
      read_reg(A_ST, rd, h);
      check("rel_status", 64'(rd), 64'h2);
      dataadr   = A_TX;
      writedata = 32'h0000_00C3;
      sbM       = 1'b1;
      memwrite  = 1'b1;
      @(negedge clk);
      memwrite  = 1'b0;
      dataadr   = '0;
      wait_idle("post_rst");
      check_rx("post_rst", 1, 48'hC3);
      check("stop_bits", 64'(stop_errs), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (legal range 2..65535).
REQ-002 Parameter FIFO_DEPTH, default 4, byte entries in the transmit FIFO (power of two, minimum 2).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 memwrite  input  1  processor store strobe, one cycle per store.
REQ-006 sbM  input  1  store-byte qualifier from the processor memory stage.
REQ-007 dataadr  input  32  processor data address.
REQ-008 writedata  input  32  processor store data.
REQ-009 readdata  output  32  load data returned to the processor.
REQ-010 hit  output  1  high when dataadr decodes to this block.
REQ-011 txd  output  1  serial line, idle high.
REQ-012 busy  output  1  high while a frame is on the line or the FIFO is non-empty.

Function
REQ-013 Address map: TXDATA = 32'h0000_00F0, STATUS = 32'h0000_00F4, full 32-bit compare; hit = (dataadr == TXDATA) or (dataadr == STATUS), combinational.
REQ-014 A store to TXDATA with FIFO not full pushes writedata[7:0], for both sbM=1 and sbM=0.
REQ-015 A store to TXDATA with FIFO full, and no pop in the same cycle, drops the byte and sets sticky OVF.
REQ-016 A push and a pop in the same cycle on a full FIFO accepts the push; occupancy stays FIFO_DEPTH; OVF is unchanged.
REQ-017 A store to STATUS with writedata[3]=1 clears OVF (write-1-to-clear); other STATUS bits ignore writes.
REQ-018 readdata is combinational: STATUS address gives {28'b0, OVF, txbusy, empty, full}; any other address, TXDATA included, gives 32'h0.
REQ-019 Stores to non-hit addresses have no effect.
REQ-020 TX FSM states: IDLE, START, DATA, STOP.
REQ-021 IDLE: txd=1; if FIFO non-empty, pop the head into the shift register and enter START next cycle.
REQ-022 START: txd=0 for CLKS_PER_BIT cycles, then DATA.
REQ-023 DATA: 8 bits LSB first, each CLKS_PER_BIT cycles, bit index 0..7, then STOP.
REQ-024 STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-025 Frame length 10*CLKS_PER_BIT cycles; back-to-back frames are separated by exactly one IDLE cycle.
REQ-026 The pop decision uses registered FIFO state: a push into an empty FIFO is popped no earlier than the following cycle.
REQ-027 txbusy = (state != IDLE); busy = txbusy or not empty.
REQ-028 txd is driven from a register (glitch-free).
REQ-029 The bit-cycle counter is sized to hold CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.

Reset
REQ-030 While reset=0: state=IDLE, txd=1, FIFO empty (pointers 0), OVF=0, bit counter and bit index 0, busy=0.
REQ-031 Reset asserted mid-frame aborts the frame immediately (txd=1 asynchronously) and discards FIFO contents.
REQ-032 The first push is accepted on the first rising edge after reset deasserts.

Structure
REQ-033 Package mmio_uart_pkg holds TXDATA/STATUS addresses, STATUS bit indices, and the tx state enum.
REQ-034 Sub-module byte_fifo (synchronous, 8-bit, parameter DEPTH, push/pop/full/empty, simultaneous push+pop when full allowed) holds the FIFO; the FSM lives in mmio_uart_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-035 Reset then idle 20 cycles -> txd=1, busy=0, STATUS read = 32'h2.
REQ-036 Store 32'h0000_00A5 to 0xF0 with sbM=1 -> txd low 2 cycles later for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 4 cycles high; busy falls after STOP.
REQ-037 Five stores on consecutive cycles to 0xF0 (0x11..0x15) -> 0x11 popped immediately, 0x12..0x15 fill the FIFO, all five frames sent, 1 idle cycle between frames, OVF=0.
REQ-038 Six consecutive stores while a frame is in flight -> sixth dropped, STATUS bit3=1; store 32'h8 to 0xF4 -> bit3=0.
REQ-039 Store to 0x0000_0100 -> hit=0, readdata=0, no frame; read 0xF0 -> readdata=0, hit=1.
REQ-040 Assert reset in DATA bit 3 -> txd=1 at once; after release, busy=0 and STATUS = 32'h2.
